// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, sizes and length decode for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_t;

  localparam int HW_W        = 16;
  localparam int BUF_ENTRIES = 3;
  localparam int BUF_W       = HW_W * BUF_ENTRIES;

  // Anything whose low two bits are not 2'b11 is a compressed (16-bit) instruction.
  function automatic logic is_rvc(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - three-entry halfword queue with 1/2-entry pop, 1/2-entry push and flush
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [1:0]        i_pop,
  input  logic [1:0]        i_push,
  input  logic [2*HW_W-1:0] i_push_data,
  output logic [1:0]        o_cnt,
  output logic [1:0]        o_nxt_cnt,
  output logic [HW_W-1:0]   o_nxt_hw0,
  output logic [HW_W-1:0]   o_nxt_hw1
);

  logic [BUF_W-1:0]  r_buf;
  logic [1:0]        r_cnt;
  logic [BUF_W-1:0]  w_shift;
  logic [BUF_W-1:0]  w_nxt;
  logic [2*HW_W-1:0] w_ins;
  logic [1:0]        w_sh_cnt;
  logic [1:0]        w_nxt_cnt;

  // Entries above cnt are kept zero, so a push can simply be OR-ed in at the tail.
  always_comb begin
    w_shift   = r_buf >> (HW_W * i_pop);
    w_sh_cnt  = r_cnt - i_pop;
    w_ins     = '0;
    if (i_push == 2'd2)
      w_ins = i_push_data;
    else if (i_push == 2'd1)
      w_ins = {{HW_W{1'b0}}, i_push_data[HW_W-1:0]};
    w_nxt     = w_shift | (BUF_W'(w_ins) << (HW_W * w_sh_cnt));
    w_nxt_cnt = w_sh_cnt + i_push;
    if (i_flush) begin
      w_nxt     = '0;
      w_nxt_cnt = 2'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf <= '0;
      r_cnt <= 2'd0;
    end else begin
      r_buf <= w_nxt;
      r_cnt <= w_nxt_cnt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_nxt_cnt = w_nxt_cnt;
  assign o_nxt_hw0 = w_nxt[HW_W-1:0];
  assign o_nxt_hw1 = w_nxt[2*HW_W-1:HW_W];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, word reads and RV32IC repacking into one instruction per handshake
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rreq,
  output logic [31:0] mem_raddr,
  input  logic        mem_rgnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [2:0]  instr_size
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_head_pc, r_fetch_addr, w_head_pc_nxt;
  logic         r_skip;
  logic         r_valid;
  logic [31:0]  r_data, r_pc;
  logic [2:0]   r_size;

  logic         w_consume, w_append, w_nxt_long, w_nxt_valid, w_unused_pc0;
  logic [1:0]   w_cons_n, w_pop, w_push, w_cnt, w_nxt_cnt;
  logic [31:0]  w_push_data;
  logic [15:0]  w_nxt_hw0, w_nxt_hw1;

  assign w_unused_pc0 = redirect_pc[0];
  assign w_consume    = r_valid && instr_ready;
  assign w_cons_n     = w_consume ? ((r_size == 3'd4) ? 2'd2 : 2'd1) : 2'd0;
  assign w_pop        = redirect ? 2'd0 : w_cons_n;
  assign mem_rreq     = !rst && (r_state == REQ) && ((w_cnt - w_cons_n) <= 2'd1);
  assign mem_raddr    = rst ? 32'h0 : r_fetch_addr;
  assign w_push       = w_append ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
  assign w_push_data  = r_skip ? {16'h0, mem_rdata[31:16]} : mem_rdata;

  fetch_buffer u_buf (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (redirect),
    .i_pop       (w_pop),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .o_cnt       (w_cnt),
    .o_nxt_cnt   (w_nxt_cnt),
    .o_nxt_hw0   (w_nxt_hw0),
    .o_nxt_hw1   (w_nxt_hw1)
  );

  // A redirect never suppresses the state move: in-flight reads must still be drained.
  always_comb begin
    w_state_nxt = r_state;
    w_append    = 1'b0;
    case (r_state)
      REQ:     if (mem_rreq && mem_rgnt) w_state_nxt = redirect ? DRAIN : WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = REQ;
          w_append    = !redirect;
        end else if (redirect) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN:   if (mem_rvalid) w_state_nxt = REQ;
      default: w_state_nxt = REQ;
    endcase
  end

  always_comb begin
    w_head_pc_nxt = r_head_pc;
    if (redirect)
      w_head_pc_nxt = {redirect_pc[31:1], 1'b0};
    else if (w_consume)
      w_head_pc_nxt = r_head_pc + {29'h0, r_size};
    w_nxt_long  = !is_rvc(w_nxt_hw0[1:0]);
    w_nxt_valid = w_nxt_long ? (w_nxt_cnt >= 2'd2) : (w_nxt_cnt >= 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= REQ;
      r_head_pc    <= {RESET_PC[31:1], 1'b0};
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_skip       <= RESET_PC[1];
      r_valid      <= 1'b0;
      r_data       <= 32'h0;
      r_pc         <= 32'h0;
      r_size       <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_head_pc <= w_head_pc_nxt;
      if (redirect) begin
        r_fetch_addr <= {redirect_pc[31:2], 2'b00};
        r_skip       <= redirect_pc[1];
      end else if (w_append) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
        r_skip       <= 1'b0;
      end
      r_valid <= w_nxt_valid;
      r_data  <= !w_nxt_valid ? 32'h0 : (w_nxt_long ? {w_nxt_hw1, w_nxt_hw0} : {16'h0, w_nxt_hw0});
      r_pc    <= w_nxt_valid ? w_head_pc_nxt : 32'h0;
      r_size  <= !w_nxt_valid ? 3'd0 : (w_nxt_long ? 3'd4 : 3'd2);
    end
  end

  assign instr_valid = r_valid;
  assign instr_data  = r_data;
  assign instr_pc    = r_pc;
  assign instr_size  = r_size;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed checks of instr_fetch against an instruction-stream model
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [2:0]  size;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rreq, mem_rgnt, mem_rvalid;
  logic [31:0] mem_raddr, mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic [2:0]  instr_size;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  acc_t        acc[$];
  logic [31:0] gnt_addrs[$];
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic        busy = 1'b0;
  int          cd = 0;
  logic [31:0] raddr_q;

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rgnt(mem_rgnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_size(instr_size)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw_at(pc);
    return (lo[1:0] == 2'b11) ? {hw_at(pc + 32'd2), lo} : {16'h0, lo};
  endfunction

  function automatic logic [2:0] model_size(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw_at(pc);
    return (lo[1:0] == 2'b11) ? 3'd4 : 3'd2;
  endfunction

  // Memory: grants at random, one read outstanding, data after a random latency.
  initial begin
    mem_rgnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rgnt   = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (busy) begin
        cd--;
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[raddr_q[9:2]];
          busy       = 1'b0;
        end
      end else if (mem_rreq && ($urandom_range(0, 99) < gnt_pct)) begin
        mem_rgnt = 1'b1;
        raddr_q  = mem_raddr;
        busy     = 1'b1;
        cd       = $urandom_range(lat_min, lat_max);
        gnt_addrs.push_back(mem_raddr);
      end
    end
  end

  // Scoreboard: the expected stream is just "decode memory at exp_pc, advance by its length".
  logic [31:0] exp_pc;
  logic        redir_chk = 1'b0, hold_chk = 1'b0;
  logic [31:0] h_data, h_pc;
  logic [2:0]  h_size;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc    = 32'h0;
        redir_chk = 1'b0;
        hold_chk  = 1'b0;
      end else begin
        if (redir_chk) check_eq("valid_after_redirect", {31'h0, instr_valid}, 32'h0);
        if (hold_chk) begin
          check_eq("hold_valid", {31'h0, instr_valid}, 32'h1);
          check_eq("hold_data", instr_data, h_data);
          check_eq("hold_pc", instr_pc, h_pc);
          check_eq("hold_size", {29'h0, instr_size}, {29'h0, h_size});
        end
        hold_chk = instr_valid && !instr_ready && !redirect;
        h_data = instr_data; h_pc = instr_pc; h_size = instr_size;
        if (redirect) begin
          exp_pc    = {redirect_pc[31:1], 1'b0};
          redir_chk = 1'b1;
        end else begin
          redir_chk = 1'b0;
          if (instr_valid && instr_ready) begin
            check_eq("pc", instr_pc, exp_pc);
            check_eq("data", instr_data, model_instr(exp_pc));
            check_eq("size", {29'h0, instr_size}, {29'h0, model_size(exp_pc)});
            acc.push_back('{pc: instr_pc, data: instr_data, size: instr_size});
            exp_pc = exp_pc + {29'h0, model_size(exp_pc)};
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    step();
    redirect = 1'b0;
    acc.delete();
    gnt_addrs.delete();
  endtask

  task automatic wait_acc(input int n);
    int k;
    k = 0;
    while (acc.size() < n && k < 300) begin
      step();
      k++;
    end
    if (acc.size() < n) check_eq("accept_timeout", acc.size(), n);
  endtask

  task automatic chk_acc(input int i, input logic [31:0] pc, input logic [31:0] data, input logic [2:0] size);
    if (i >= acc.size()) begin
      check_eq("acc_missing", acc.size(), i + 1);
    end else begin
      check_eq("acc_pc", acc[i].pc, pc);
      check_eq("acc_data", acc[i].data, data);
      check_eq("acc_size", {29'h0, acc[i].size}, {29'h0, size});
    end
  endtask

  initial begin
    int k;
    logic [31:0] s_data, s_pc;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h0000_0013; mem[8'h01] = 32'h0010_0093;
    mem[8'h10] = 32'h4501_4501;
    mem[8'h20] = 32'h0013_4501; mem[8'h21] = 32'h0000_0000;
    mem[8'h40] = 32'hAAAA_4501; mem[8'h41] = 32'h0000_0013;
    mem[8'h80] = 32'h0010_0093; mem[8'h81] = 32'h4501_4501;
    for (int i = 8'hC0; i < 8'hD0; i++) mem[i] = 32'h0000_0013;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rreq", {31'h0, mem_rreq}, 32'h0);
    check_eq("rst_raddr", mem_raddr, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_data", instr_data, 32'h0);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_size", {29'h0, instr_size}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_rreq", {31'h0, mem_rreq}, 32'h1);
    check_eq("first_raddr", mem_raddr, 32'h0);

    wait_acc(2);
    chk_acc(0, 32'h0, 32'h0000_0013, 3'd4);
    chk_acc(1, 32'h4, 32'h0010_0093, 3'd4);

    step(); do_redirect(32'h40); wait_acc(2);
    chk_acc(0, 32'h40, 32'h0000_4501, 3'd2);
    chk_acc(1, 32'h42, 32'h0000_4501, 3'd2);

    step(); do_redirect(32'h80); wait_acc(2);
    chk_acc(0, 32'h80, 32'h0000_4501, 3'd2);
    chk_acc(1, 32'h82, 32'h0000_0013, 3'd4);

    // Odd-halfword target with the consumer stalled until the buffer fills.
    instr_ready = 1'b0;
    step(); do_redirect(32'h102);
    repeat (10) step();
    check_eq("redir_raddr", (gnt_addrs.size() > 0) ? gnt_addrs[0] : 32'hFFFF_FFFF, 32'h100);
    s_data = instr_data; s_pc = instr_pc;
    check_eq("stall_pc", s_pc, 32'h102);
    check_eq("stall_data", s_data, 32'h0000_AAAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_rreq", {31'h0, mem_rreq}, 32'h0);
      check_eq("stall_cnt", {30'h0, dut.u_buf.o_cnt}, 32'd3);
      check_eq("stall_hold_data", instr_data, s_data);
      step();
    end
    instr_ready = 1'b1;
    wait_acc(3);
    chk_acc(0, 32'h102, 32'h0000_AAAA, 3'd2);
    chk_acc(1, 32'h104, 32'h0000_0013, 3'd4);
    chk_acc(2, 32'h108, 32'h0000_0000, 3'd2);

    // Redirect while a slow read is in flight; the old stream must not leak through.
    lat_min = 4; lat_max = 4;
    step(); do_redirect(32'h300); wait_acc(2);
    k = 0;
    while (!(busy && cd >= 2) && k < 100) begin step(); k++; end
    check_eq("busy_seen", {31'h0, busy}, 32'h1);
    do_redirect(32'h200); wait_acc(2);
    check_eq("drain_raddr", (gnt_addrs.size() > 0) ? gnt_addrs[0] : 32'hFFFF_FFFF, 32'h200);
    chk_acc(0, 32'h200, 32'h0010_0093, 3'd4);
    chk_acc(1, 32'h204, 32'h0000_4501, 3'd2);

    // Random phase: random memory, grant rate, latency, backpressure and redirects.
    instr_ready = 1'b0;
    lat_min = 1; lat_max = 3; gnt_pct = 70;
    step();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_redirect($urandom);
    for (int c = 0; c < 4000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
      end else begin
        redirect = 1'b0;
      end
      step();
    end
    redirect = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
